// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the execute-stage ALU and the ALU control stage:
//   - the eight 4-bit ALU control codes
//   - the iterative-shift FSM state encoding
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_LUI  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1110;
   localparam logic [3:0] ALU_SRAV = 4'b1111;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // True for the two codes that go through the iterative shifter.
   function automatic logic is_shift_op(input logic [3:0] ctrl);
      return (ctrl == ALU_SRA) || (ctrl == ALU_SRAV);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// ---------------------------------------------------------------------------
// alu_comb_core
// Purely combinational single-cycle operation evaluator.
// Ports:
//   ctrl_i     ALU control code
//   src1_i     rs operand
//   src2_i     rt / immediate operand
//   result_o   single-cycle result (src2 for shift codes: zero-amount shift)
//   illegal_o  high when ctrl_i is not a supported code
// ---------------------------------------------------------------------------
module alu_comb_core
   import alu_ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [3:0]    ctrl_i,
   input  logic [DW-1:0] src1_i,
   input  logic [DW-1:0] src2_i,
   output logic [DW-1:0] result_o,
   output logic          illegal_o
);

   // Single-cycle operation select and unsupported-code detection.
   always_comb begin
      result_o  = {DW{1'b0}};
      illegal_o = 1'b0;
      case (ctrl_i)
         ALU_AND:  result_o = src1_i & src2_i;
         ALU_OR:   result_o = src1_i | src2_i;
         ALU_ADD:  result_o = src1_i + src2_i;
         ALU_SUB:  result_o = src1_i - src2_i;
         ALU_SLT: begin
            if ($signed(src1_i) < $signed(src2_i)) begin
               result_o = {{(DW-1){1'b0}}, 1'b1};
            end else begin
               result_o = {DW{1'b0}};
            end
         end
         ALU_LUI:  result_o = {src2_i[15:0], {(DW-16){1'b0}}};
         // A shift by zero is just a pass-through of the operand.
         ALU_SRA:  result_o = src2_i;
         ALU_SRAV: result_o = src2_i;
         default: begin
            result_o  = {DW{1'b0}};
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_iter_exec.sv
// ---------------------------------------------------------------------------
// alu_iter_exec
// Execute-stage ALU. Logic/arithmetic ops complete in one registered cycle;
// arithmetic right shifts iterate one bit per cycle behind a busy/done
// handshake so the controller can stall.
// Ports:
//   clk_i      system clock (rising edge)
//   rst_i      synchronous active-high reset
//   start_i    request, sampled only while busy_o=0
//   ctrl_i     ALU control code
//   src1_i     rs operand (also the amount for srav)
//   src2_i     rt / immediate operand
//   shamt_i    instruction shamt field (amount for sra)
//   busy_o     high while a shift is iterating
//   done_o     one-cycle pulse: result_o/zero_o/illegal_o valid
//   result_o   registered result, held until the next done_o
//   zero_o     registered (result == 0)
//   illegal_o  registered, set with done_o for an unsupported code
// ---------------------------------------------------------------------------
module alu_iter_exec
   import alu_ctrl_pkg::*;
#(
   parameter int DW  = 32,
   parameter int SHW = 5
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [3:0]     ctrl_i,
   input  logic [DW-1:0]  src1_i,
   input  logic [DW-1:0]  src2_i,
   input  logic [SHW-1:0] shamt_i,
   output logic           busy_o,
   output logic           done_o,
   output logic [DW-1:0]  result_o,
   output logic           zero_o,
   output logic           illegal_o
);

   state_e         state_q,   state_d;
   logic [DW-1:0]  work_q,    work_d;
   logic [SHW-1:0] cnt_q,     cnt_d;
   logic [DW-1:0]  result_q,  result_d;
   logic           zero_q,    zero_d;
   logic           illegal_q, illegal_d;
   logic           done_q,    done_d;

   logic [DW-1:0]  core_result_s;
   logic           core_illegal_s;
   logic [SHW-1:0] amt_s;
   logic [DW-1:0]  work_sh_s;

   alu_comb_core #(.DW(DW)) u_core (
      .ctrl_i    (ctrl_i),
      .src1_i    (src1_i),
      .src2_i    (src2_i),
      .result_o  (core_result_s),
      .illegal_o (core_illegal_s)
   );

   // Shift amount source: srav takes it from rs, sra from the shamt field.
   always_comb begin
      if (ctrl_i == ALU_SRAV) begin
         amt_s = src1_i[SHW-1:0];
      end else begin
         amt_s = shamt_i;
      end
   end

   // One-bit arithmetic right shift of the working register (MSB replicated).
   assign work_sh_s = {work_q[DW-1], work_q[DW-1:1]};

   // Next-state and output-register logic.
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (is_shift_op(ctrl_i) && (amt_s != {SHW{1'b0}})) begin
                  work_d  = src2_i;
                  cnt_d   = amt_s;
                  state_d = SHIFT;
               end else begin
                  result_d  = core_result_s;
                  zero_d    = (core_result_s == {DW{1'b0}});
                  illegal_d = core_illegal_s;
                  done_d    = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            work_d = work_sh_s;
            cnt_d  = cnt_q - SHW'(1);
            // Last shift edge: the shifted value is the final result.
            if (cnt_q == SHW'(1)) begin
               result_d  = work_sh_s;
               zero_d    = (work_sh_s == {DW{1'b0}});
               illegal_d = 1'b0;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         work_q    <= {DW{1'b0}};
         cnt_q     <= {SHW{1'b0}};
         result_q  <= {DW{1'b0}};
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
         done_q    <= done_d;
      end
   end

   assign busy_o    = (state_q == SHIFT);
   assign done_o    = done_q;
   assign result_o  = result_q;
   assign zero_o    = zero_q;
   assign illegal_o = illegal_q;

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code and the two operands.
- Logic/arithmetic ops complete in one registered cycle; arithmetic right shifts (sra/srav) iterate one bit per cycle.
- Uses a start/busy/done handshake so the datapath controller can stall while a shift is in progress.
- Drives the write-back result and the branch zero flag.

Parameters:
- DW, 32, operand/result width.
- SHW, 5, shift-amount width (log2 DW).

Ports:
- clk_i  in  1  system clock, all state updates on rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- start_i  in  1  request; sampled only when busy_o=0.
- ctrl_i  in  4  ALU control code from ALU control stage.
- src1_i  in  DW  rs operand.
- src2_i  in  DW  rt / immediate operand.
- shamt_i  in  SHW  instruction shamt field (used by sra).
- busy_o  out  1  high while a shift is iterating.
- done_o  out  1  one-cycle pulse: result_o/zero_o valid.
- result_o  out  DW  registered result, held until next done_o.
- zero_o  out  1  registered (result==0), updated with result_o.
- illegal_o  out  1  registered, set with done_o when ctrl_i was unsupported.

Behaviour:
- Reset (rst_i=1 at a rising edge): state=IDLE, busy_o=0, done_o=0, result_o=0, zero_o=1, illegal_o=0, shift counter=0. Reset mid-shift aborts the operation, with no done_o.
- Control codes:
  - 0000 AND: src1&src2.
  - 0001 OR: src1|src2.
  - 0010 ADD: src1+src2, modulo 2^DW, no overflow flag.
  - 0110 SUB: src1-src2, modulo 2^DW.
  - 0111 SLT: signed compare, result 1 if $signed(src1)<$signed(src2), else 0.
  - 1010 LUI: {src2[15:0],16'b0}.
  - 1110 SRA: src2 >>> shamt_i.
  - 1111 SRAV: src2 >>> src1[SHW-1:0].
  - Any other code: result 0, illegal_o=1.
- FSM states: IDLE, SHIFT.
- IDLE, start_i=1, non-shift code (accepted at edge N): result_o, zero_o, illegal_o load at edge N. done_o=1 during cycle N..N+1, i.e. exactly one cycle. State stays IDLE.
- IDLE, start_i=1, shift code with amount k:
  - k=0: behaves as non-shift; result=src2, latency 1.
  - k>0: at edge N, working reg=src2, cnt=k, state goes to SHIFT, busy_o=1.
  - In SHIFT, each edge: working reg arithmetic-shifts right by 1 (MSB replicated) and cnt decrements.
  - At the edge where cnt goes from 1 to 0: result_o/zero_o load, done_o pulses, state returns to IDLE, busy_o=0.
  - Total: done_o observed k cycles after the accepting edge plus one; k shift edges.
- Operands are captured at the accepting edge. Input changes during SHIFT are ignored.
- start_i while busy_o=1 is ignored, not queued. The controller must hold the request.
- Back-to-back: in the cycle done_o=1 the FSM is IDLE, so a new start_i is accepted that same edge. Non-shift ops sustain 1 op/cycle with done_o held high continuously.
- result_o and zero_o change only on a done edge, otherwise hold.
- Max shift k=31: done at edge N+31, busy_o high for 31 cycles.
- Negative src2 shifted by 31 yields all-ones (32'hFFFFFFFF).

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - localparams for the eight 4-bit control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_LUI, ALU_SRA, ALU_SRAV), shared with the ALU control stage.
  - FSM state encoding (IDLE=1'b0, SHIFT=1'b1).
- One natural sub-module: alu_comb_core, a purely combinational single-cycle op evaluator (AND/OR/ADD/SUB/SLT/LUI plus illegal detect).
- The top holds the FSM, shift register/counter and output registers.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> result_o=0, zero_o=1, busy_o=0, done_o=0; no done_o while start_i=0.
- ADD/SUB/SLT: ctrl 0010, src1=32'h7FFFFFFF, src2=1 -> next cycle done_o=1, result_o=32'h80000000, zero_o=0. Ctrl 0110 with 5,5 -> result 0, zero_o=1. Ctrl 0111 with src1=32'hFFFFFFFF, src2=1 -> result 1.
- SRA iterate: ctrl 1110, src2=32'h80000010, shamt_i=4 -> busy_o high for 4 cycles, done_o on 5th cycle, result_o=32'hF8000001. start_i pulsed mid-shift is ignored (no extra done_o).
- SRAV edge cases: src1=32'h20 (amount 0), src2=32'h1234 -> 1-cycle latency, result 32'h1234. src1=31, src2=32'h80000000 -> 31 busy cycles, result 32'hFFFFFFFF.
- Back-to-back and illegal: start_i held high with OR, LUI(src2=32'hABCD), code 0011 on consecutive cycles -> done_o high 3 consecutive cycles, results = OR value, 32'hABCD0000, 0 with illegal_o=1 on third only.
- Reset mid-shift: srav amount 20, assert rst_i at shift cycle 7 -> no done_o, busy_o=0, result_o=0 next cycle; a new add is accepted immediately after reset release.
